// File: rtl/output_buff_pkg.sv
// rtl/output_buff_pkg.sv - shared state type, lane indices and idle levels for output_buff
package output_buff_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int NUM_LANES  = 4;
  localparam int LANE_REF   = 0;
  localparam int LANE_SIG_A = 1;
  localparam int LANE_SIG_B = 2;
  localparam int LANE_SIG_C = 3;

  localparam logic REF_IDLE = 1'b1;
  localparam logic SIG_IDLE = 1'b0;

endpackage

// File: rtl/serial_out_lane.sv
// rtl/serial_out_lane.sv - one serial lane: private word copy and a registered output bit
module serial_out_lane #(
  parameter int   NDATA      = 128,
  parameter logic IDLE_LEVEL = 1'b0,
  parameter int   NDATA_LOG  = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 finish,
  input  logic [NDATA_LOG-1:0] idx,
  input  logic [NDATA-1:0]     din,
  output logic                 sout
);

  logic [NDATA-1:0] word_q;

  // idx is the index the counter will hold after this edge, so sout stays aligned with cntout
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      sout   <= IDLE_LEVEL;
    end else if (load) begin
      word_q <= din;
      sout   <= din[idx];
    end else if (finish) begin
      sout   <= IDLE_LEVEL;
    end else if (shift) begin
      sout   <= word_q[idx];
    end
  end

endmodule

// File: rtl/output_buff.sv
// rtl/output_buff.sv - parallel-to-serial output buffer; OUTPUT_BUFF_MSB_FIRST_EN selects MSB-first order
module output_buff
  import output_buff_pkg::*;
#(
  parameter int NDATA     = 128,
  localparam int NDATA_LOG = $clog2(NDATA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [NDATA-1:0]     dinRef,
  input  logic [NDATA-1:0]     dinSigA,
  input  logic [NDATA-1:0]     dinSigB,
  input  logic [NDATA-1:0]     dinSigC,
  output logic [3:0]           dout,
  output logic [NDATA_LOG-1:0] cntout,
  output logic                 busy,
  output logic                 done
);

  localparam logic [NDATA_LOG-1:0] IDX_LO = '0;
  localparam logic [NDATA_LOG-1:0] IDX_HI = NDATA_LOG'(NDATA - 1);
  localparam logic [NDATA_LOG-1:0] ONE    = NDATA_LOG'(1);
`ifdef OUTPUT_BUFF_MSB_FIRST_EN
  localparam logic [NDATA_LOG-1:0] START  = IDX_HI;
  localparam logic [NDATA_LOG-1:0] LAST   = IDX_LO;
`else
  localparam logic [NDATA_LOG-1:0] START  = IDX_LO;
  localparam logic [NDATA_LOG-1:0] LAST   = IDX_HI;
`endif

  state_t               state_q, state_d;
  logic [NDATA_LOG-1:0] cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 accept, step, finish, advance;
  logic [NUM_LANES-1:0] lane_bits;

  assign accept  = (state_q == IDLE) && load_valid;
  assign step    = (state_q == SHIFT) && ena;
  assign finish  = step && (cnt_q == LAST);
  assign advance = step && (cnt_q != LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= START;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = START;
        if (accept) state_d = SHIFT;
      end
      SHIFT: begin
        if (finish) begin
          state_d = IDLE;
          cnt_d   = START;
          done_d  = 1'b1;
        end else if (advance) begin
`ifdef OUTPUT_BUFF_MSB_FIRST_EN
          cnt_d = cnt_q - ONE;
`else
          cnt_d = cnt_q + ONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == SHIFT);
    done       = done_q;
    cntout     = cnt_q;
    dout       = lane_bits;
  end

  serial_out_lane #(.NDATA(NDATA), .IDLE_LEVEL(REF_IDLE)) u_lane_ref (
    .clk(clk), .rst(rst), .load(accept), .shift(advance), .finish(finish),
    .idx(cnt_d), .din(dinRef), .sout(lane_bits[LANE_REF])
  );

  serial_out_lane #(.NDATA(NDATA), .IDLE_LEVEL(SIG_IDLE)) u_lane_sig_a (
    .clk(clk), .rst(rst), .load(accept), .shift(advance), .finish(finish),
    .idx(cnt_d), .din(dinSigA), .sout(lane_bits[LANE_SIG_A])
  );

  serial_out_lane #(.NDATA(NDATA), .IDLE_LEVEL(SIG_IDLE)) u_lane_sig_b (
    .clk(clk), .rst(rst), .load(accept), .shift(advance), .finish(finish),
    .idx(cnt_d), .din(dinSigB), .sout(lane_bits[LANE_SIG_B])
  );

  serial_out_lane #(.NDATA(NDATA), .IDLE_LEVEL(SIG_IDLE)) u_lane_sig_c (
    .clk(clk), .rst(rst), .load(accept), .shift(advance), .finish(finish),
    .idx(cnt_d), .din(dinSigC), .sout(lane_bits[LANE_SIG_C])
  );

endmodule

// File: tb/tb_output_buff.sv
// tb/tb_output_buff.sv - scoreboard bench for output_buff with a frame-level reference model
module tb_output_buff;

  localparam int N   = 8;
  localparam int LOG = $clog2(N);
`ifdef OUTPUT_BUFF_MSB_FIRST_EN
  localparam bit MSB = 1'b1;
`else
  localparam bit MSB = 1'b0;
`endif
  localparam logic [LOG-1:0] START = MSB ? LOG'(N - 1) : '0;

  typedef struct {
    logic [3:0]     d;
    logic [LOG-1:0] c;
    bit             last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ena = 1'b1;
  logic           load_valid = 1'b0;
  logic           load_ready;
  logic [N-1:0]   dinRef = '0, dinSigA = '0, dinSigB = '0, dinSigC = '0;
  logic [3:0]     dout;
  logic [LOG-1:0] cntout;
  logic           busy, done;

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  bit   mon_en = 1'b0;
  bit   done_exp = 1'b0;
  bit   ena_rand = 1'b0;
  bit   jitter = 1'b0;

  output_buff #(.NDATA(N)) dut (
    .clk(clk), .rst(rst), .ena(ena), .load_valid(load_valid), .load_ready(load_ready),
    .dinRef(dinRef), .dinSigA(dinSigA), .dinSigB(dinSigB), .dinSigC(dinSigC),
    .dout(dout), .cntout(cntout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Background ena randomisation and input word churn, applied 1 time unit after each edge
  always @(posedge clk) begin
    #1;
    if (ena_rand) ena = ($urandom_range(0, 3) != 0);
    if (jitter && !load_valid) begin
      dinRef  = N'($urandom);
      dinSigA = N'($urandom);
      dinSigB = N'($urandom);
      dinSigC = N'($urandom);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      bit popped_last;
      popped_last = 1'b0;
      chk("done", done, done_exp);
      if (busy) begin
        chk("load_ready_busy", load_ready, 1'b0);
        if (q.size() == 0) begin
          chk("unexpected_busy", busy, 1'b0);
        end else begin
          chk("dout", dout, q[0].d);
          chk("cntout", cntout, q[0].c);
          if (ena && !rst) begin
            popped_last = q[0].last;
            void'(q.pop_front());
          end
        end
      end else begin
        chk("idle_dout", dout, 4'b0001);
        chk("idle_cntout", cntout, START);
        chk("idle_load_ready", load_ready, 1'b1);
      end
      done_exp = popped_last && !rst;
      if (rst) q.delete();
    end
  end

  task automatic push_frame(input logic [N-1:0] r, a, b, c);
    for (int i = 0; i < N; i++) begin
      exp_t e;
      int   idx;
      idx    = MSB ? (N - 1 - i) : i;
      e.d    = {c[idx], b[idx], a[idx], r[idx]};
      e.c    = LOG'(idx);
      e.last = (i == N - 1);
      q.push_back(e);
    end
  endtask

  task automatic load_frame(input logic [N-1:0] r, a, b, c);
    int guard;
    guard = 0;
    @(posedge clk); #2;
    while (!load_ready && guard < 500) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 500) begin
      chk("load_ready_timeout", load_ready, 1'b1);
    end else begin
      dinRef = r; dinSigA = a; dinSigB = b; dinSigC = c;
      load_valid = 1'b1;
      push_frame(r, a, b, c);
      @(posedge clk); #2;
      load_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((q.size() != 0 || busy) && guard < 2000) begin
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 2000) chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("rst_dout", dout, 4'b0001);
    chk("rst_cntout", cntout, START);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_load_ready", load_ready, 1'b1);
    mon_en = 1'b1;

    // Directed frame, ena held high
    load_frame(8'hA5, 8'h3C, 8'hFF, 8'h00);
    wait_idle();
    load_frame(8'hA5, 8'h01, 8'h00, 8'h80);
    wait_idle();

    // Enable stalls mid-frame
    load_frame(8'h5A, 8'hC3, 8'h0F, 8'hF0);
    @(posedge clk); #2; ena = 1'b1;
    @(posedge clk); #2; ena = 1'b0;
    @(posedge clk); #2; ena = 1'b0;
    @(posedge clk); #2; ena = 1'b1;
    wait_idle();

    // Load attempt during SHIFT with changing words
    load_frame(8'h96, 8'h69, 8'h33, 8'hCC);
    jitter = 1'b1;
    @(posedge clk); #2;
    load_valid = 1'b1;
    @(posedge clk); #2;
    chk("load_during_shift_ready", load_ready, 1'b0);
    load_valid = 1'b0;
    wait_idle();

    // Reset at the fourth bit of a frame
    load_frame(8'h12, 8'h34, 8'h56, 8'h78);
    begin
      int guard;
      guard = 0;
      while (!(busy && cntout == (MSB ? LOG'(N - 4) : LOG'(3))) && guard < 100) begin
        @(posedge clk); #2;
        guard++;
      end
      chk("reach_bit3", guard < 100, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_dout", dout, 4'b0001);
    load_frame(8'hE7, 8'h18, 8'hAA, 8'h55);
    wait_idle();

    // Randomised frames with random ena and random load attempts
    ena_rand = 1'b1;
    for (int f = 0; f < 25; f++) begin
      load_frame(N'($urandom), N'($urandom), N'($urandom), N'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #2;
        load_valid = 1'b1;
        @(posedge clk); #2;
        load_valid = 1'b0;
      end
    end
    wait_idle();
    ena_rand = 1'b0;
    ena = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("final_queue_empty", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
